// File: rtl/mult_result_accum.sv
// mult_result_accum: drains a programmed number of serial_mult products through
// the valid/get handshake and presents their wide sum on a valid/ready port.
module mult_result_accum #(
  parameter int RES_W   = 16,
  parameter int ACC_W   = 20,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic             mult_valid,
  input  logic [RES_W-1:0] mult_result,
  output logic             mult_get,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc_data,
  input  logic             acc_ready,
  output logic             overflow
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    ACK     = 3'd2,
    RELEASE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] len_clamp_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ovf_nxt_s;
  logic [ACC_W:0]   sum_s;

  assign len_clamp_s = (len > MAX_LEN_C) ? MAX_LEN_C : len;
  // One extra bit so the carry out of ACC_W can feed the sticky overflow flag.
  assign sum_s = {1'b0, acc_data} + {{(ACC_W+1-RES_W){1'b0}}, mult_result};

  // Next-state, counter and accumulator update
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_data;
    ovf_nxt_s   = overflow;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_nxt_s = {ACC_W{1'b0}};
          ovf_nxt_s = 1'b0;
          cnt_nxt_s = len_clamp_s;
          if (len != CNT_ZERO) begin
            state_nxt_s = COLLECT;
          end else begin
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (mult_valid) begin
          acc_nxt_s   = sum_s[ACC_W-1:0];
          ovf_nxt_s   = overflow | sum_s[ACC_W];
          cnt_nxt_s   = cnt_r - CNT_ONE;
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      ACK: begin
        state_nxt_s = RELEASE;
      end
      RELEASE: begin
        // A product still presented after get must not be counted twice.
        if (!mult_valid) begin
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = COLLECT;
          end
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      acc_data  <= {ACC_W{1'b0}};
      overflow  <= 1'b0;
      busy      <= 1'b0;
      mult_get  <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      acc_data  <= acc_nxt_s;
      overflow  <= ovf_nxt_s;
      busy      <= (state_nxt_s != IDLE);
      mult_get  <= (state_nxt_s == ACK);
      acc_valid <= (state_nxt_s == HOLD);
    end
  end

endmodule

// File: tb/tb_mult_result_accum.sv
// tb_mult_result_accum: directed scoreboard bench; a narrow-accumulator copy
// (ACC_W=18) is instantiated alongside to exercise overflow.
module tb_mult_result_accum;

  localparam int CNT_W = 5;

  typedef struct packed {
    logic [19:0] data;
    logic        ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             sel;
  logic             start_s;
  logic [CNT_W-1:0] len;
  logic             mult_valid;
  logic [15:0]      mult_result;
  logic             acc_ready;

  logic        busy_a, get_a, av_a, ov_a;
  logic [19:0] data_a;
  logic        busy_b, get_b, av_b, ov_b;
  logic [17:0] data_b;

  logic        busy_s, get_s, av_s, ov_s;
  logic [19:0] data_s;
  logic        start_a, start_b;

  int   vectors = 0;
  int   miscompares = 0;
  int   get_cnt = 0;
  logic get_prev = 1'b0;
  logic av_prev = 1'b0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  assign start_a = start_s & ~sel;
  assign start_b = start_s & sel;
  assign busy_s  = sel ? busy_b : busy_a;
  assign get_s   = sel ? get_b : get_a;
  assign av_s    = sel ? av_b : av_a;
  assign ov_s    = sel ? ov_b : ov_a;
  assign data_s  = sel ? {2'b00, data_b} : data_a;

  mult_result_accum dut (
    .clk(clk), .rst(rst), .start(start_a), .len(len), .busy(busy_a),
    .mult_valid(mult_valid), .mult_result(mult_result), .mult_get(get_a),
    .acc_valid(av_a), .acc_data(data_a), .acc_ready(acc_ready), .overflow(ov_a)
  );

  mult_result_accum #(.ACC_W(18)) dut18 (
    .clk(clk), .rst(rst), .start(start_b), .len(len), .busy(busy_b),
    .mult_valid(mult_valid), .mult_result(mult_result), .mult_get(get_b),
    .acc_valid(av_b), .acc_data(data_b), .acc_ready(acc_ready), .overflow(ov_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: each new sum presented is compared with the oldest expectation
  always @(negedge clk) begin
    if (av_s && !av_prev) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: sum %0d presented with nothing expected", data_s);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_acc_data", data_s, e.data);
        chk("sb_overflow", ov_s, e.ovf);
      end
    end
    av_prev = av_s;
  end

  // get pulse monitor: counts pulses and requires each to be one cycle wide
  always @(negedge clk) begin
    if (get_s) begin
      get_cnt++;
      chk("get_width", get_prev, 1'b0);
    end
    get_prev = get_s;
  end

  task automatic go(input int n);
    @(posedge clk); #1;
    start_s = 1'b1;
    len = n[CNT_W-1:0];
    @(posedge clk); #1;
    start_s = 1'b0;
  endtask

  task automatic feed(input logic [15:0] p, input int extra);
    int t;
    t = 0;
    @(posedge clk); #1;
    mult_valid = 1'b1;
    mult_result = p;
    @(negedge clk);
    while (!get_s && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("get_timeout", get_s, 1'b1);
    repeat (extra) @(posedge clk);
    @(posedge clk); #1;
    mult_valid = 1'b0;
  endtask

  task automatic wait_hold();
    int t;
    t = 0;
    @(negedge clk);
    while (!av_s && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hold_timeout", av_s, 1'b1);
  endtask

  task automatic handoff(input logic [19:0] expd);
    wait_hold();
    @(posedge clk); #1;
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", av_s, 1'b0);
    chk("busy_idle", busy_s, 1'b0);
    chk("data_persist", data_s, expd);
  endtask

  initial begin
    int g0;
    rst = 1'b1; sel = 1'b0; start_s = 1'b0; len = '0;
    mult_valid = 1'b0; mult_result = 16'd0; acc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_get", get_a, 1'b0);
    chk("rst_valid", av_a, 1'b0);
    chk("rst_data", data_a, 20'd0);
    chk("rst_ovf", ov_a, 1'b0);

    // len=3, products 10/20/30
    g0 = get_cnt;
    sbq.push_back('{20'd60, 1'b0});
    go(3);
    feed(16'd10, 0); feed(16'd20, 0); feed(16'd30, 0);
    handoff(20'd60);
    chk("t1_gets", get_cnt - g0, 3);

    // len=0 goes straight to HOLD with a zero sum
    g0 = get_cnt;
    sbq.push_back('{20'd0, 1'b0});
    go(0);
    @(negedge clk);
    chk("t2_valid", av_s, 1'b1);
    chk("t2_data", data_s, 20'd0);
    handoff(20'd0);
    chk("t2_gets", get_cnt - g0, 0);

    // HOLD stalls with acc_ready low; start pulsed meanwhile must be ignored
    sbq.push_back('{20'd15, 1'b0});
    go(1);
    feed(16'd15, 0);
    wait_hold();
    g0 = get_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start_s = (i == 4);
      len = 5'd2;
      @(negedge clk);
      chk("t3_valid", av_s, 1'b1);
      chk("t3_data", data_s, 20'd15);
    end
    start_s = 1'b0;
    handoff(20'd15);
    repeat (3) @(negedge clk);
    chk("t3_no_queue", busy_s, 1'b0);
    chk("t3_gets", get_cnt - g0, 0);

    // narrow accumulator wraps and flags overflow
    sel = 1'b1;
    sbq.push_back('{20'd65531, 1'b1});
    go(5);
    for (int i = 0; i < 5; i++) feed(16'hFFFF, 0);
    handoff(20'd65531);
    sel = 1'b0;

    // product held valid two cycles past get is counted once
    sbq.push_back('{20'd16, 1'b0});
    go(2);
    feed(16'd7, 2); feed(16'd9, 2);
    handoff(20'd16);

    // len above MAX_LEN clamps to 16 products
    g0 = get_cnt;
    sbq.push_back('{20'd16000, 1'b0});
    go(20);
    for (int i = 0; i < 16; i++) feed(16'd1000, 0);
    handoff(20'd16000);
    chk("clamp_gets", get_cnt - g0, 16);

    // reset mid-operation aborts it
    go(4);
    feed(16'd100, 0); feed(16'd200, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    g0 = get_cnt;
    chk("t6_busy", busy_s, 1'b0);
    chk("t6_get", get_s, 1'b0);
    chk("t6_valid", av_s, 1'b0);
    chk("t6_data", data_s, 20'd0);
    chk("t6_ovf", ov_s, 1'b0);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_get", get_cnt - g0, 0);
    sbq.push_back('{20'd7, 1'b0});
    go(1);
    feed(16'd7, 0);
    handoff(20'd7);

    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
